// File: rtl/tp_rom_loader_if.sv
// -----------------------------------------------------------------------------
// tp_rom_loader_if
// Groups the download-source side (ioctl_*), the target-memory write port
// (dn_*, mem_ready) and the status outputs of the ROM loader into one bundle.
//
//   slave  modport : the loader itself (consumes ioctl_* and mem_ready,
//                    produces the write port, stall and status signals)
//   master modport : the surrounding system / testbench
//
// Signals
//   ioctl_download  download session active
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      25-bit byte address
//   ioctl_dout      byte data
//   ioctl_wait      stall request back to the download source
//   mem_ready       target memory accepts the presented write this cycle
//   dn_addr/dn_data/dn_region/dn_wr  presented write, held until accepted
//   core_reset      reset to the game core
//   load_done       a valid image has been loaded
//   byte_count      accepted in-range bytes this session
//   checksum        modulo-2^16 sum of accepted bytes
//   overflow        an out-of-range address was written this session
// -----------------------------------------------------------------------------
interface tp_rom_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_ready;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [1:0]  dn_region;
  logic        core_reset;
  logic        load_done;
  logic [16:0] byte_count;
  logic [15:0] checksum;
  logic        overflow;

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, mem_ready,
    output ioctl_wait, dn_addr, dn_data, dn_wr, dn_region,
    output core_reset, load_done, byte_count, checksum, overflow
  );

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, mem_ready,
    input  ioctl_wait, dn_addr, dn_data, dn_wr, dn_region,
    input  core_reset, load_done, byte_count, checksum, overflow
  );
endinterface

// File: rtl/tp_rom_loader.sv
// -----------------------------------------------------------------------------
// tp_rom_loader
// Receives a ROM image byte-by-byte from a download source, forwards each
// in-range byte to the target memory with a held write request, classifies
// it into one of four regions, keeps a byte count and checksum, and holds the
// game core in reset until the image is in place plus HOLD_CYCLES cycles.
//
// Ports
//   clk_sys  system clock, all registers on its rising edge
//   reset    synchronous, active-high
//   bus      tp_rom_loader_if.slave (download source, memory write port,
//            stall and status signals)
//
// Parameters
//   RGN1_BASE/RGN2_BASE/RGN3_BASE  first address of regions 1..3 (region 0
//                                  starts at 0)
//   ROM_SIZE                       one past the last valid download address
//   HOLD_CYCLES                    core-reset cycles after the download ends
// -----------------------------------------------------------------------------
module tp_rom_loader #(
  parameter logic [15:0] RGN1_BASE   = 16'h6000,
  parameter logic [15:0] RGN2_BASE   = 16'h8000,
  parameter logic [15:0] RGN3_BASE   = 16'hE000,
  parameter logic [16:0] ROM_SIZE    = 17'h10000,
  parameter int          HOLD_CYCLES = 16
) (
  input logic           clk_sys,
  input logic           reset,
  tp_rom_loader_if.slave bus
);

  localparam logic [24:0] ROM_LIMIT  = {8'd0, ROM_SIZE};
  localparam logic [24:0] RGN1_LIMIT = {9'd0, RGN1_BASE};
  localparam logic [24:0] RGN2_LIMIT = {9'd0, RGN2_BASE};
  localparam logic [24:0] RGN3_LIMIT = {9'd0, RGN3_BASE};
  localparam logic [15:0] HOLD_LAST  = (HOLD_CYCLES > 1) ? 16'(HOLD_CYCLES - 1) : 16'd0;
  localparam logic [16:0] COUNT_MAX  = 17'h1FFFF;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HOLD, RUN} state_t;

  state_t      state_q, state_d;
  logic        dn_wr_q, dn_wr_d;
  logic [15:0] dn_addr_q, dn_addr_d;
  logic [7:0]  dn_data_q, dn_data_d;
  logic [1:0]  dn_region_q, dn_region_d;
  logic        skid_vld_q, skid_vld_d;
  logic [15:0] skid_addr_q, skid_addr_d;
  logic [7:0]  skid_data_q, skid_data_d;
  logic [1:0]  skid_region_q, skid_region_d;
  logic [16:0] byte_count_q, byte_count_d;
  logic [15:0] checksum_q, checksum_d;
  logic        overflow_q, overflow_d;
  logic        load_done_q, load_done_d;
  logic        core_reset_q, core_reset_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;

  logic        strobe;
  logic        in_range;
  logic        new_wr;
  logic        accept;
  logic [1:0]  new_region;

  // Classify the incoming byte address; the highest matching base wins.
  always_comb begin
    if (bus.ioctl_addr >= RGN3_LIMIT) begin
      new_region = 2'd3;
    end else if (bus.ioctl_addr >= RGN2_LIMIT) begin
      new_region = 2'd2;
    end else if (bus.ioctl_addr >= RGN1_LIMIT) begin
      new_region = 2'd1;
    end else begin
      new_region = 2'd0;
    end
  end

  // Strobes are only honoured while a session is loading.
  assign strobe   = bus.ioctl_wr && (state_q == LOAD);
  assign in_range = (bus.ioctl_addr < ROM_LIMIT);
  assign new_wr   = strobe && in_range;
  assign accept   = dn_wr_q && bus.mem_ready;

  // Next-state logic for the write slot, skid slot, counters and FSM.
  always_comb begin
    state_d       = state_q;
    dn_wr_d       = dn_wr_q;
    dn_addr_d     = dn_addr_q;
    dn_data_d     = dn_data_q;
    dn_region_d   = dn_region_q;
    skid_vld_d    = skid_vld_q;
    skid_addr_d   = skid_addr_q;
    skid_data_d   = skid_data_q;
    skid_region_d = skid_region_q;
    byte_count_d  = byte_count_q;
    checksum_d    = checksum_q;
    overflow_d    = overflow_q;
    load_done_d   = load_done_q;
    hold_cnt_d    = hold_cnt_q;

    if (accept) begin
      if (byte_count_q != COUNT_MAX) begin
        byte_count_d = byte_count_q + 17'd1;
      end
      checksum_d = checksum_q + {8'd0, dn_data_q};
    end

    if (strobe && !in_range) begin
      overflow_d = 1'b1;
    end

    // The presented slot frees up when it is empty or accepted this cycle.
    // A skidded byte always goes out before any byte arriving now, which then
    // takes the skid slot instead.
    if (!dn_wr_q || accept) begin
      if (skid_vld_q) begin
        dn_wr_d     = 1'b1;
        dn_addr_d   = skid_addr_q;
        dn_data_d   = skid_data_q;
        dn_region_d = skid_region_q;
        skid_vld_d  = new_wr;
        if (new_wr) begin
          skid_addr_d   = bus.ioctl_addr[15:0];
          skid_data_d   = bus.ioctl_dout;
          skid_region_d = new_region;
        end
      end else if (new_wr) begin
        dn_wr_d     = 1'b1;
        dn_addr_d   = bus.ioctl_addr[15:0];
        dn_data_d   = bus.ioctl_dout;
        dn_region_d = new_region;
      end else begin
        dn_wr_d = 1'b0;
      end
    end else if (new_wr) begin
      skid_vld_d    = 1'b1;
      skid_addr_d   = bus.ioctl_addr[15:0];
      skid_data_d   = bus.ioctl_dout;
      skid_region_d = new_region;
    end

    case (state_q)
      IDLE: begin
        if (bus.ioctl_download) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!bus.ioctl_download) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // A download restarted here waits for the last write to land first.
        if (!dn_wr_q && !skid_vld_q) begin
          state_d    = bus.ioctl_download ? LOAD : HOLD;
          hold_cnt_d = 16'd0;
        end
      end
      HOLD: begin
        if (bus.ioctl_download) begin
          state_d = LOAD;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d     = RUN;
          load_done_d = (byte_count_q != 17'd0) && !overflow_q;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      RUN: begin
        if (bus.ioctl_download) begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every fresh session starts from clean statistics.
    if ((state_d == LOAD) && (state_q != LOAD)) begin
      byte_count_d = 17'd0;
      checksum_d   = 16'd0;
      overflow_d   = 1'b0;
      load_done_d  = 1'b0;
    end

    core_reset_d = (state_d != RUN);
  end

  // State register; reset discards both the presented and the skidded write.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= IDLE;
      dn_wr_q       <= 1'b0;
      dn_addr_q     <= 16'd0;
      dn_data_q     <= 8'd0;
      dn_region_q   <= 2'd0;
      skid_vld_q    <= 1'b0;
      skid_addr_q   <= 16'd0;
      skid_data_q   <= 8'd0;
      skid_region_q <= 2'd0;
      byte_count_q  <= 17'd0;
      checksum_q    <= 16'd0;
      overflow_q    <= 1'b0;
      load_done_q   <= 1'b0;
      core_reset_q  <= 1'b1;
      hold_cnt_q    <= 16'd0;
    end else begin
      state_q       <= state_d;
      dn_wr_q       <= dn_wr_d;
      dn_addr_q     <= dn_addr_d;
      dn_data_q     <= dn_data_d;
      dn_region_q   <= dn_region_d;
      skid_vld_q    <= skid_vld_d;
      skid_addr_q   <= skid_addr_d;
      skid_data_q   <= skid_data_d;
      skid_region_q <= skid_region_d;
      byte_count_q  <= byte_count_d;
      checksum_q    <= checksum_d;
      overflow_q    <= overflow_d;
      load_done_q   <= load_done_d;
      core_reset_q  <= core_reset_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  // The stall must react in the same cycle the memory refuses a write.
  assign bus.ioctl_wait = dn_wr_q && !bus.mem_ready;
  assign bus.dn_wr      = dn_wr_q;
  assign bus.dn_addr    = dn_addr_q;
  assign bus.dn_data    = dn_data_q;
  assign bus.dn_region  = dn_region_q;
  assign bus.byte_count = byte_count_q;
  assign bus.checksum   = checksum_q;
  assign bus.overflow   = overflow_q;
  assign bus.load_done  = load_done_q;
  assign bus.core_reset = core_reset_q;

endmodule

// File: tb/tb_tp_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_tp_rom_loader
// Drives directed and randomized download sessions into tp_rom_loader and
// compares its outputs with a queue-based reference of the writes the memory
// should see, plus running count/sum/overflow totals per session.
// -----------------------------------------------------------------------------
module tb_tp_rom_loader;

  localparam logic [15:0] RGN1_BASE   = 16'h6000;
  localparam logic [15:0] RGN2_BASE   = 16'h8000;
  localparam logic [15:0] RGN3_BASE   = 16'hE000;
  localparam logic [16:0] ROM_SIZE    = 17'h10000;
  localparam int          HOLD_CYCLES = 16;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [1:0]  region;
  } wr_t;

  logic clk_sys = 1'b0;
  logic reset;

  tp_rom_loader_if bus ();

  tp_rom_loader #(
    .RGN1_BASE  (RGN1_BASE),
    .RGN2_BASE  (RGN2_BASE),
    .RGN3_BASE  (RGN3_BASE),
    .ROM_SIZE   (ROM_SIZE),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int  total = 0;
  int  bad = 0;
  wr_t exp_q[$];
  int  model_cnt = 0;
  int  model_sum = 0;
  bit  model_ovf = 1'b0;
  bit  in_load = 1'b0;
  bit  last_wait = 1'b0;
  bit  mon_en = 1'b0;

  // Region a byte belongs to, straight from the base-address table.
  function automatic logic [1:0] regionOf(input logic [24:0] a);
    if (a >= 25'(RGN3_BASE)) return 2'd3;
    if (a >= 25'(RGN2_BASE)) return 2'd2;
    if (a >= 25'(RGN1_BASE)) return 2'd1;
    return 2'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic resetModel();
    exp_q.delete();
    model_cnt = 0;
    model_sum = 0;
    model_ovf = 1'b0;
  endtask

  // One clock cycle of source activity; the stall seen in this cycle is kept
  // so a one-cycle-late source can honour it on the next cycle.
  task automatic applyStimulus(input logic wr, input logic [24:0] addr,
                               input logic [7:0] data, input logic ready);
    wr_t w;
    bus.ioctl_wr   = wr;
    bus.ioctl_addr = addr;
    bus.ioctl_dout = data;
    bus.mem_ready  = ready;
    #1 last_wait = bus.ioctl_wait;
    @(posedge clk_sys);
    #1;
    bus.ioctl_wr = 1'b0;
    if (wr && in_load) begin
      if (addr < 25'(ROM_SIZE)) begin
        w.addr   = addr[15:0];
        w.data   = data;
        w.region = regionOf(addr);
        exp_q.push_back(w);
        if (model_cnt < 'h1FFFF) model_cnt++;
        model_sum = (model_sum + int'(data)) % 65536;
      end else begin
        model_ovf = 1'b1;
      end
    end
  endtask

  task automatic startSession();
    bus.ioctl_download = 1'b1;
    tick();
    in_load   = 1'b1;
    last_wait = 1'b0;
    resetModel();
  endtask

  // Ends the session and waits (bounded) for the core to be released.
  task automatic endSession(output int edges);
    bus.ioctl_download = 1'b0;
    bus.mem_ready      = 1'b1;
    in_load            = 1'b0;
    edges              = 0;
    while (bus.core_reset === 1'b1 && edges < 1000) begin
      tick();
      edges++;
    end
    checkOutput("core_reset_released", bus.core_reset, 32'd0);
    checkOutput("byte_count", bus.byte_count, model_cnt);
    checkOutput("checksum", bus.checksum, model_sum);
    checkOutput("overflow", bus.overflow, model_ovf);
    checkOutput("load_done", bus.load_done, (model_cnt != 0) && !model_ovf);
    checkOutput("writes_outstanding", exp_q.size(), 32'd0);
  endtask

  task automatic randomSession(input int n, input bit allow_ovf);
    logic        ready;
    logic [24:0] addr;
    logic [7:0]  data;
    int          edges;
    startSession();
    for (int k = 0; k < n; k++) begin
      ready = ($urandom_range(0, 3) != 0);
      if (!last_wait && ($urandom_range(0, 1) == 1)) begin
        if (allow_ovf && ($urandom_range(0, 7) == 0)) begin
          addr = 25'h10000 + 25'($urandom_range(0, 255));
        end else begin
          addr = 25'($urandom_range(0, 65535));
        end
        data = 8'($urandom_range(0, 255));
        applyStimulus(1'b1, addr, data, ready);
      end else begin
        applyStimulus(1'b0, 25'd0, 8'd0, ready);
      end
    end
    endSession(edges);
  endtask

  // Memory-side monitor: a write is presented exactly while the reference
  // still owes one, it must match the oldest owed write, and it retires when
  // the memory is ready.
  always @(negedge clk_sys) begin
    if (mon_en) begin
      checkOutput("dn_wr_presence", bus.dn_wr, exp_q.size() != 0);
      checkOutput("ioctl_wait", bus.ioctl_wait, (exp_q.size() != 0) && !bus.mem_ready);
      if (bus.dn_wr === 1'b1 && exp_q.size() != 0) begin
        checkOutput("presented_write", {bus.dn_addr, bus.dn_data, bus.dn_region}, exp_q[0]);
        if (bus.mem_ready && !reset) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int edges;
    int waits;

    reset              = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = 25'd0;
    bus.ioctl_dout     = 8'd0;
    bus.mem_ready      = 1'b1;
    tick();
    tick();

    $display("[TB] reset values");
    checkOutput("rst_dn_wr", bus.dn_wr, 32'd0);
    checkOutput("rst_ioctl_wait", bus.ioctl_wait, 32'd0);
    checkOutput("rst_dn_addr", bus.dn_addr, 32'd0);
    checkOutput("rst_dn_data", bus.dn_data, 32'd0);
    checkOutput("rst_dn_region", bus.dn_region, 32'd0);
    checkOutput("rst_byte_count", bus.byte_count, 32'd0);
    checkOutput("rst_checksum", bus.checksum, 32'd0);
    checkOutput("rst_overflow", bus.overflow, 32'd0);
    checkOutput("rst_load_done", bus.load_done, 32'd0);
    checkOutput("rst_core_reset", bus.core_reset, 32'd1);

    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    $display("[TB] strobe while idle");
    applyStimulus(1'b1, 25'h0100, 8'hAB, 1'b1);
    checkOutput("idle_ignored", bus.dn_wr, 32'd0);
    checkOutput("idle_core_reset", bus.core_reset, 32'd1);

    $display("[TB] three-region load");
    startSession();
    applyStimulus(1'b1, 25'h0000, 8'h11, 1'b1);
    checkOutput("rgn_wr0", bus.dn_wr, 32'd1);
    checkOutput("rgn_0", bus.dn_region, 32'd0);
    applyStimulus(1'b1, 25'h6000, 8'h22, 1'b1);
    checkOutput("rgn_wr1", bus.dn_wr, 32'd1);
    checkOutput("rgn_1", bus.dn_region, 32'd1);
    applyStimulus(1'b1, 25'hE001, 8'h33, 1'b1);
    checkOutput("rgn_wr3", bus.dn_wr, 32'd1);
    checkOutput("rgn_3", bus.dn_region, 32'd3);
    endSession(edges);
    // One edge leaves LOAD, one leaves an empty DRAIN, then HOLD_CYCLES in HOLD.
    checkOutput("hold_length", edges, HOLD_CYCLES + 2);
    checkOutput("three_sum", bus.checksum, 32'h0066);
    checkOutput("three_count", bus.byte_count, 32'd3);

    $display("[TB] memory back-pressure with skid");
    startSession();
    applyStimulus(1'b1, 25'h0123, 8'hA5, 1'b1);
    waits = 0;
    applyStimulus(1'b1, 25'h8100, 8'h5A, 1'b0);
    waits += int'(last_wait);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 25'd0, 8'd0, 1'b0);
      waits += int'(last_wait);
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 25'd0, 8'd0, 1'b1);
      waits += int'(last_wait);
    end
    checkOutput("wait_cycles", waits, 32'd4);
    endSession(edges);
    checkOutput("skid_count", bus.byte_count, 32'd2);

    $display("[TB] out-of-range address");
    startSession();
    applyStimulus(1'b1, 25'h10000, 8'h77, 1'b1);
    checkOutput("oor_no_wr", bus.dn_wr, 32'd0);
    checkOutput("oor_overflow", bus.overflow, 32'd1);
    endSession(edges);
    checkOutput("oor_load_done", bus.load_done, 32'd0);

    $display("[TB] 256 bytes of 0xFF");
    startSession();
    checkOutput("ovf_cleared", bus.overflow, 32'd0);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 25'(i), 8'hFF, 1'b1);
    end
    endSession(edges);
    checkOutput("ff_sum", bus.checksum, 32'hFF00);
    checkOutput("ff_count", bus.byte_count, 32'd256);

    $display("[TB] restart during hold");
    startSession();
    checkOutput("load_done_cleared", bus.load_done, 32'd0);
    applyStimulus(1'b1, 25'h4000, 8'h10, 1'b1);
    applyStimulus(1'b1, 25'h9000, 8'h20, 1'b1);
    applyStimulus(1'b0, 25'd0, 8'd0, 1'b1);
    bus.ioctl_download = 1'b0;
    in_load            = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("hold_core_reset", bus.core_reset, 32'd1);
    end
    checkOutput("hold_count_kept", bus.byte_count, model_cnt);
    startSession();
    checkOutput("restart_core_reset", bus.core_reset, 32'd1);
    checkOutput("restart_count", bus.byte_count, 32'd0);
    checkOutput("restart_sum", bus.checksum, 32'd0);
    applyStimulus(1'b1, 25'hC000, 8'h42, 1'b1);
    applyStimulus(1'b1, 25'hF000, 8'h24, 1'b1);
    endSession(edges);

    $display("[TB] reset mid-load with write pending");
    startSession();
    applyStimulus(1'b1, 25'h1234, 8'h5A, 1'b0);
    reset              = 1'b1;
    bus.ioctl_download = 1'b0;
    tick();
    resetModel();
    in_load = 1'b0;
    checkOutput("abort_dn_wr", bus.dn_wr, 32'd0);
    checkOutput("abort_core_reset", bus.core_reset, 32'd1);
    checkOutput("abort_count", bus.byte_count, 32'd0);
    checkOutput("abort_wait", bus.ioctl_wait, 32'd0);
    reset = 1'b0;
    applyStimulus(1'b1, 25'h0200, 8'h99, 1'b1);
    checkOutput("abort_idle", bus.dn_wr, 32'd0);
    tick();
    checkOutput("abort_idle_core_reset", bus.core_reset, 32'd1);

    $display("[TB] randomized sessions");
    randomSession(80, 1'b0);
    randomSession(60, 1'b1);
    randomSession(60, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
